sgmii_link_monitor: RTL and testbench

Post-reset link supervisor for the SGMII SERDES/PCS channel, sitting directly downstream of the quad/TX/RX PCS reset sequencer. It waits for both PCS resets to release, then qualifies RX CDR lock and signal presence over a debounce window before declaring the link up. On sustained loss or lock timeout it re-issues a local RX SERDES + RX PCS reset sequence and retries. It reports link status and the retry count to the MAC/management logic.

---
 rtl/sgmii_link_monitor.sv | 173 +++++++++++++++++
 tb/tb_sgmii_link_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_link_monitor.sv
// SGMII RX link supervisor: qualifies CDR lock/signal after PCS reset, re-resets the RX path on loss or lock timeout.
// Define SGMII_LINK_MON_RETRY_LIMIT_EN to give up (sticky fail) after RETRY_MAX consecutive re-resets.
module sgmii_link_monitor #(
  parameter int LOCK_WAIT    = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOS_FILTER   = 8,
  parameter int RST_PULSE    = 16,
  parameter int RETRY_MAX    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_pcs_rst_in,
  input  logic       rx_pcs_rst_in,
  input  logic       rx_cdr_lol,
  input  logic       rx_los_low,
  output logic       rx_serdes_rst_out,
  output logic       rx_pcs_rst_out,
  output logic       link_ok,
  output logic [3:0] retry_cnt,
  output logic       fail
);

  localparam int GW = $clog2(LOCK_WAIT);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int BW = (LOS_FILTER > 1) ? $clog2(LOS_FILTER) : 1;
  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOS_FILTER - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(RST_PULSE - 1);

  if (LOCK_WAIT < 2 || LOCK_TIMEOUT <= LOCK_WAIT || LOS_FILTER < 1 ||
      RST_PULSE < 1 || RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_param_check
    $error("sgmii_link_monitor: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_LINK_UP,
    S_RX_RST_SERDES,
    S_RX_RST_PCS
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
    , S_FAIL
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [TW-1:0]   to_cnt, to_nxt;
  logic [BW-1:0]   bad_cnt, bad_nxt;
  logic [PW-1:0]   ph_cnt, ph_nxt;
  logic [3:0]      retry_nxt;
  logic [1:0]      lol_sync, los_sync;
  logic            bad, pcs_rst, enter_rst;

  // Synchronizers come out of reset reporting "bad" so nothing qualifies on stale levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lol_sync <= 2'b11;
      los_sync <= 2'b11;
    end else begin
      lol_sync <= {lol_sync[0], rx_cdr_lol};
      los_sync <= {los_sync[0], rx_los_low};
    end
  end

  assign bad     = lol_sync[1] | los_sync[1];
  assign pcs_rst = tx_pcs_rst_in | rx_pcs_rst_in;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    to_nxt    = to_cnt;
    bad_nxt   = bad_cnt;
    ph_nxt    = ph_cnt;
    retry_nxt = retry_cnt;
    enter_rst = 1'b0;

    if (pcs_rst) begin
      state_nxt = S_IDLE;
      retry_nxt = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          good_nxt = bad ? '0 : good_cnt + 1'b1;
          to_nxt   = to_cnt + 1'b1;
          if (!bad && good_cnt == GOOD_LAST) begin
            state_nxt = S_LINK_UP;
            retry_nxt = '0;
          end else if (to_cnt == TO_LAST) begin
            enter_rst = 1'b1;
          end
        end
        S_LINK_UP: begin
          bad_nxt = bad ? bad_cnt + 1'b1 : '0;
          if (bad && bad_cnt == BAD_LAST) enter_rst = 1'b1;
        end
        S_RX_RST_SERDES: begin
          ph_nxt = ph_cnt + 1'b1;
          if (ph_cnt == PH_LAST) state_nxt = S_RX_RST_PCS;
        end
        S_RX_RST_PCS: begin
          ph_nxt = ph_cnt + 1'b1;
          if (ph_cnt == PH_LAST) state_nxt = S_WAIT_LOCK;
        end
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
        S_FAIL: state_nxt = S_FAIL;
`endif
        default: state_nxt = S_IDLE;
      endcase

      if (enter_rst) begin
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
        if (retry_cnt >= 4'(RETRY_MAX)) begin
          state_nxt = S_FAIL;
          retry_nxt = 4'(RETRY_MAX);
        end else begin
          state_nxt = S_RX_RST_SERDES;
          retry_nxt = retry_cnt + 4'd1;
        end
`else
        state_nxt = S_RX_RST_SERDES;
        retry_nxt = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
`endif
      end
    end

    // Every state entry starts its run/phase counters from zero, so none can wrap.
    if (state_nxt != state) begin
      good_nxt = '0;
      to_nxt   = '0;
      bad_nxt  = '0;
      ph_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      good_cnt          <= '0;
      to_cnt            <= '0;
      bad_cnt           <= '0;
      ph_cnt            <= '0;
      retry_cnt         <= '0;
      link_ok           <= 1'b0;
      rx_serdes_rst_out <= 1'b0;
      rx_pcs_rst_out    <= 1'b0;
    end else begin
      state             <= state_nxt;
      good_cnt          <= good_nxt;
      to_cnt            <= to_nxt;
      bad_cnt           <= bad_nxt;
      ph_cnt            <= ph_nxt;
      retry_cnt         <= retry_nxt;
      link_ok           <= (state_nxt == S_LINK_UP);
      rx_serdes_rst_out <= (state_nxt == S_RX_RST_SERDES);
      rx_pcs_rst_out    <= (state_nxt == S_RX_RST_PCS);
    end
  end

`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fail <= 1'b0;
    else        fail <= (state_nxt == S_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_sgmii_link_monitor.sv
// Randomized + directed bench for sgmii_link_monitor against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_sgmii_link_monitor;

  localparam int LW = 16, LT = 64, LF = 4, RP = 8, RM = 3;
  localparam int M_DOWN = 0, M_ACQ = 1, M_UP = 2, M_SERDES = 3, M_PCS = 4, M_GIVEUP = 5;

  logic       clk = 1'b0;
  logic       rst_n, tx_pcs_rst_in, rx_pcs_rst_in, rx_cdr_lol, rx_los_low;
  logic       rx_serdes_rst_out, rx_pcs_rst_out, link_ok, fail;
  logic [3:0] retry_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sgmii_link_monitor #(
    .LOCK_WAIT(LW), .LOCK_TIMEOUT(LT), .LOS_FILTER(LF), .RST_PULSE(RP), .RETRY_MAX(RM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_pcs_rst_in(tx_pcs_rst_in), .rx_pcs_rst_in(rx_pcs_rst_in),
    .rx_cdr_lol(rx_cdr_lol), .rx_los_low(rx_los_low),
    .rx_serdes_rst_out(rx_serdes_rst_out), .rx_pcs_rst_out(rx_pcs_rst_out),
    .link_ok(link_ok), .retry_cnt(retry_cnt), .fail(fail)
  );

  // Reference model: mode plus entry timestamp; run lengths come from last-good/last-bad timestamps.
  int     m_mode, m_retry;
  longint cyc, ent, last_bad, last_good;
  bit     sq[$];
  bit     m_b, m_go;

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  initial begin
    m_mode = M_DOWN; m_retry = 0; cyc = 0; ent = 0; last_bad = 0; last_good = 0;
    sq = '{1'b1, 1'b1};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_DOWN; m_retry = 0; cyc = 0; ent = 0; last_bad = 0; last_good = 0;
        sq = '{1'b1, 1'b1};
      end else begin
        cyc = cyc + 1;
        m_b = sq.pop_front();
        sq.push_back(rx_cdr_lol | rx_los_low);
        if (m_b) last_bad = cyc; else last_good = cyc;
        m_go = 1'b0;
        if (tx_pcs_rst_in || rx_pcs_rst_in) begin
          m_mode = M_DOWN; m_retry = 0;
        end else begin
          case (m_mode)
            M_DOWN: begin m_mode = M_ACQ; ent = cyc; end
            M_ACQ: begin
              if (!m_b && cyc - lmax(last_bad, ent) >= LW) begin
                m_mode = M_UP; ent = cyc; m_retry = 0;
              end else if (cyc - ent >= LT) m_go = 1'b1;
            end
            M_UP: if (m_b && cyc - lmax(last_good, ent) >= LF) m_go = 1'b1;
            M_SERDES: if (cyc - ent >= RP) begin m_mode = M_PCS; ent = cyc; end
            M_PCS: if (cyc - ent >= RP) begin m_mode = M_ACQ; ent = cyc; end
            default: ;
          endcase
          if (m_go) begin
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
            if (m_retry >= RM) begin m_mode = M_GIVEUP; m_retry = RM; end
            else begin m_mode = M_SERDES; ent = cyc; m_retry = m_retry + 1; end
`else
            m_mode = M_SERDES; ent = cyc;
            if (m_retry < 15) m_retry = m_retry + 1;
`endif
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_vec();
    return {m_mode == M_UP, m_mode == M_SERDES, m_mode == M_PCS, 4'(m_retry), m_mode == M_GIVEUP};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic at_edge(input longint e);
    int g = 0;
    while (cyc < e && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < e) chk("edge_wait_timeout", cyc, e);
  endtask

  task automatic bring_up(input string tag);
    longint b0;
    b0 = cyc; tx_pcs_rst_in = 1'b0; rx_pcs_rst_in = 1'b0;
    at_edge(b0 + 16); chk({tag, "_link_early"}, link_ok, 0);
    at_edge(b0 + 17); chk({tag, "_link_up"}, link_ok, 1);
    chk({tag, "_retry"}, retry_cnt, 0);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      chk("cycle_outputs", {link_ok, rx_serdes_rst_out, rx_pcs_rst_out, retry_cnt, fail}, exp_vec());
      chk("reset_overlap", rx_serdes_rst_out & rx_pcs_rst_out, 0);
    end
  end

  initial begin
    longint c0, kk, a0;
    bit lo, hi;
    int r, n_att;
    rst_n = 1'b1; tx_pcs_rst_in = 1'b1; rx_pcs_rst_in = 1'b1; rx_cdr_lol = 1'b0; rx_los_low = 1'b0;
    #2 rst_n = 1'b0;
    #20 chk("reset_outputs", {link_ok, rx_serdes_rst_out, rx_pcs_rst_out, retry_cnt, fail}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bring_up("bringup");

    // Glitch of LOS_FILTER-1 synchronized bad cycles must be filtered.
    c0 = cyc; kk = c0 + 1; rx_cdr_lol = 1'b1;
    at_edge(kk + 2); rx_cdr_lol = 1'b0;
    lo = 1'b1; hi = 1'b0;
    for (longint e = kk + 3; e <= kk + 10; e++) begin
      at_edge(e);
      lo = lo & link_ok;
      hi = hi | rx_serdes_rst_out | rx_pcs_rst_out;
    end
    chk("glitch3_link_held", lo, 1);
    chk("glitch3_no_reset", hi, 0);

    // LOS_FILTER bad cycles trip the re-reset sequence.
    c0 = cyc; kk = c0 + 1; rx_cdr_lol = 1'b1;
    at_edge(kk + 3); rx_cdr_lol = 1'b0;
    at_edge(kk + 4);  chk("glitch4_link_before", link_ok, 1);
    at_edge(kk + 5);  chk("glitch4_link_drop", link_ok, 0);
    chk("glitch4_serdes_rise", rx_serdes_rst_out, 1);
    chk("glitch4_retry", retry_cnt, 1);
    at_edge(kk + 12); chk("serdes_last", rx_serdes_rst_out, 1);
    at_edge(kk + 13); chk("serdes_fall", rx_serdes_rst_out, 0);
    chk("pcs_rise", rx_pcs_rst_out, 1);
    at_edge(kk + 20); chk("pcs_last", rx_pcs_rst_out, 1);
    at_edge(kk + 21); chk("pcs_fall", rx_pcs_rst_out, 0);
    at_edge(kk + 37); chk("relock_link", link_ok, 1);
    chk("relock_retry", retry_cnt, 0);

    // Intermittent lock: 15 good, 1 bad, then a full run of 16 good.
    rx_pcs_rst_in = 1'b1; @(negedge clk); rx_pcs_rst_in = 1'b0;
    c0 = cyc;
    at_edge(c0 + 14); rx_cdr_lol = 1'b1;
    at_edge(c0 + 15); rx_cdr_lol = 1'b0;
    at_edge(c0 + 17); chk("intermittent_no_link17", link_ok, 0);
    at_edge(c0 + 32); chk("intermittent_no_link32", link_ok, 0);
    at_edge(c0 + 33); chk("intermittent_link33", link_ok, 1);

    // Lock timeout, repeated retries.
    tx_pcs_rst_in = 1'b1; rx_los_low = 1'b1; @(negedge clk); tx_pcs_rst_in = 1'b0;
    c0 = cyc; a0 = c0 + 1;
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
    n_att = 4;
`else
    n_att = 17;
`endif
    for (int a = 1; a <= n_att; a++) begin
      at_edge(a0 + 63); chk("timeout_early", rx_serdes_rst_out, 0);
      at_edge(a0 + 64);
`ifdef SGMII_LINK_MON_RETRY_LIMIT_EN
      if (a == 4) begin
        chk("giveup_fail", fail, 1);
        chk("giveup_retry", retry_cnt, RM);
        chk("giveup_serdes", rx_serdes_rst_out, 0);
      end else begin
        chk("timeout_serdes", rx_serdes_rst_out, 1);
        chk("timeout_retry", retry_cnt, a);
      end
`else
      chk("timeout_serdes", rx_serdes_rst_out, 1);
      chk("timeout_retry", retry_cnt, (a > 15) ? 15 : a);
`endif
      a0 = a0 + 64 + 2 * RP;
    end
    repeat (100) @(negedge clk);

    rx_los_low = 1'b0; tx_pcs_rst_in = 1'b1;
    @(negedge clk);
    chk("pcs_rst_clears", {link_ok, rx_serdes_rst_out, rx_pcs_rst_out, retry_cnt, fail}, 0);
    repeat (3) @(negedge clk);
    bring_up("after_timeout");

    // Preemption by pcs_rst during the SERDES reset phase.
    c0 = cyc; kk = c0 + 1; rx_cdr_lol = 1'b1;
    at_edge(kk + 5); chk("preempt_serdes_on", rx_serdes_rst_out, 1);
    rx_cdr_lol = 1'b0;
    at_edge(kk + 7); tx_pcs_rst_in = 1'b1;
    at_edge(kk + 8);
    chk("preempt_outputs", {link_ok, rx_serdes_rst_out, rx_pcs_rst_out, retry_cnt, fail}, 0);
    repeat (3) @(negedge clk);
    bring_up("after_preempt");

    // Randomized traffic checked cycle-by-cycle by the model.
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) tx_pcs_rst_in = 1'b1; else rx_pcs_rst_in = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_pcs_rst_in = 1'b0; rx_pcs_rst_in = 1'b0;
      end else if (r == 1) begin
        rx_los_low = 1'b1;
        repeat ($urandom_range(60, 150)) @(negedge clk);
        rx_los_low = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) rx_cdr_lol = 1'b1; else rx_los_low = 1'b1;
        repeat ($urandom_range(1, 7)) @(negedge clk);
        rx_cdr_lol = 1'b0; rx_los_low = 1'b0;
      end
      repeat ($urandom_range(3, 40)) @(negedge clk);
    end

    rx_cdr_lol = 1'b0; rx_los_low = 1'b0; tx_pcs_rst_in = 1'b1;
    repeat (3) @(negedge clk);
    bring_up("final");

    // Asynchronous reset while the link is up.
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("async_reset", {link_ok, rx_serdes_rst_out, rx_pcs_rst_out, retry_cnt, fail}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
